wb_stage_cp0: RTL

//  Write-back stage of the 5-stage MIPS pipeline. It sits directly downstream of the memory stage.
//  - Latches the memory-to-writeback bus and drives the register-file write port.
//  - Contains a CP0 subset: BadVAddr is excluded; Count, Compare, Status, Cause and EPC are included.
//  - Commits exceptions and ERET, and raises a pipeline-wide flush with a redirect PC.
//  - Reports the pending-interrupt condition to decode.

---
 rtl/wb_stage_cp0.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stage_cp0.sv
// Write-back stage of the 5-stage MIPS pipeline, with a CP0 subset (Count, Compare, Status, Cause, EPC).
// Commits exceptions and ERET, redirects fetch on a flush, and reports pending interrupts to decode.
module wb_stage_cp0 #(
   parameter int          MS_TO_WS_BUS_WD = 149,
   parameter logic [31:0] EX_ENTRY        = 32'hbfc00380
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ms_to_ws_valid,
   input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic                       ws_allowin,
   input  logic [5:0]                 hw_int,
   output logic                       rf_we,
   output logic [4:0]                 rf_waddr,
   output logic [31:0]                rf_wdata,
   output logic                       ws_flush,
   output logic [31:0]                ws_flush_pc,
   output logic                       int_pending,
   output logic [31:0]                debug_wb_pc
);

   logic                       ws_valid;
   logic                       ws_ready_go;
   logic [MS_TO_WS_BUS_WD-1:0] ws_bus;

   logic [31:0] rt_value;
   logic        eret;
   logic        bd;
   logic        mtc0_we;
   logic [4:0]  cp0_addr;
   logic        res_from_cp0;
   logic        ex;
   logic [4:0]  excode;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] final_result;
   logic [31:0] pc;
   logic        unused_alu_result;

   assign rt_value          = ws_bus[148:117];
   assign eret              = ws_bus[116];
   assign bd                = ws_bus[115];
   assign mtc0_we           = ws_bus[114];
   assign cp0_addr          = ws_bus[113:109];
   assign res_from_cp0      = ws_bus[108];
   assign unused_alu_result = ^ws_bus[107:76];
   assign ex                = ws_bus[75];
   assign excode            = ws_bus[74:70];
   assign gr_we             = ws_bus[69];
   assign dest              = ws_bus[68:64];
   assign final_result      = ws_bus[63:32];
   assign pc                = ws_bus[31:0];

   logic ex_commit;
   logic eret_commit;
   logic mtc0_commit;

   assign ex_commit   = ws_valid & ex;
   assign eret_commit = ws_valid & eret & ~ex;
   assign mtc0_commit = ws_valid & mtc0_we & ~ex;

   assign ws_ready_go = 1'b1;
   assign ws_allowin  = ~ws_valid | ws_ready_go;

   // Flush beats a same-cycle load so nothing younger than the faulting instruction survives.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid <= 1'b0;
         ws_bus   <= '0;
      end else begin
         if (ws_flush)
            ws_valid <= 1'b0;
         else if (ws_allowin)
            ws_valid <= ms_to_ws_valid;
         if (ms_to_ws_valid && ws_allowin && !ws_flush)
            ws_bus <= ms_to_ws_bus;
      end
   end

   logic [7:0]  status_im;
   logic        status_exl;
   logic        status_ie;
   logic        cause_bd;
   logic        cause_ti;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_excode;
   logic [31:0] epc;
   logic [31:0] count;
   logic [31:0] compare;
   logic        tick;

   logic [7:2]  cause_ip_hw;
   logic [31:0] status_val;
   logic [31:0] cause_val;
   logic [31:0] cp0_rdata;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic        wr_count;
   logic        wr_compare;

   assign wr_status  = mtc0_commit && (cp0_addr == 5'd12);
   assign wr_cause   = mtc0_commit && (cp0_addr == 5'd13);
   assign wr_epc     = mtc0_commit && (cp0_addr == 5'd14);
   assign wr_count   = mtc0_commit && (cp0_addr == 5'd9);
   assign wr_compare = mtc0_commit && (cp0_addr == 5'd11);

   assign cause_ip_hw = hw_int | {cause_ti, 5'b0};
   assign status_val  = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
   assign cause_val   = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                         1'b0, cause_excode, 2'b0};

   // A nested exception (EXL already set) keeps the original EPC and BD.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_im    <= 8'h00;
         status_exl   <= 1'b0;
         status_ie    <= 1'b0;
         cause_bd     <= 1'b0;
         cause_ti     <= 1'b0;
         cause_ip_sw  <= 2'b00;
         cause_excode <= 5'd0;
         epc          <= 32'h0;
         count        <= 32'h0;
         compare      <= 32'h0;
         tick         <= 1'b0;
      end else begin
         tick <= ~tick;
         if (wr_count)
            count <= rt_value;
         else if (tick)
            count <= count + 32'd1;

         if (wr_compare) begin
            compare  <= rt_value;
            cause_ti <= 1'b0;
         end else if (count == compare) begin
            cause_ti <= 1'b1;
         end

         if (ex_commit) begin
            status_exl   <= 1'b1;
            cause_excode <= excode;
            if (!status_exl) begin
               epc      <= bd ? (pc - 32'd4) : pc;
               cause_bd <= bd;
            end
         end else if (eret_commit) begin
            status_exl <= 1'b0;
         end else begin
            if (wr_status) begin
               status_im  <= rt_value[15:8];
               status_exl <= rt_value[1];
               status_ie  <= rt_value[0];
            end
            if (wr_cause)
               cause_ip_sw <= rt_value[9:8];
            if (wr_epc)
               epc <= rt_value;
         end
      end
   end

   always_comb begin
      cp0_rdata = 32'h0;
      case (cp0_addr)
         5'd9:    cp0_rdata = count;
         5'd11:   cp0_rdata = compare;
         5'd12:   cp0_rdata = status_val;
         5'd13:   cp0_rdata = cause_val;
         5'd14:   cp0_rdata = epc;
         default: cp0_rdata = 32'h0;
      endcase
   end

   assign rf_we       = ws_valid & gr_we & ~ex;
   assign rf_waddr    = dest;
   assign rf_wdata    = res_from_cp0 ? cp0_rdata : final_result;
   assign ws_flush    = ex_commit | eret_commit;
   assign ws_flush_pc = ex_commit ? EX_ENTRY : epc;
   assign debug_wb_pc = pc;
   assign int_pending = (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;

endmodule
